// File: rtl/quad_step_if.sv
// quad_step_if - signal bundle between a quadrature step decoder and its user.
//
// Carries the encoder pins and control inputs toward the decoder and the
// decoded step/direction/error results back.
//   master : drives enc_a, enc_b, enable, clr_err; receives the results
//   slave  : the decoder side (receives pins/controls, drives results)
// Parameter ERR_CNT_W sets the width of err_cnt and must match the decoder.
interface quad_step_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 enc_a;
  logic                 enc_b;
  logic                 enable;
  logic                 clr_err;
  logic                 step;
  logic                 up_down;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [1:0]           ab_state;

  modport master (
    output enc_a, enc_b, enable, clr_err,
    input  step, up_down, err_pulse, err_cnt, ab_state
  );

  modport slave (
    input  enc_a, enc_b, enable, clr_err,
    output step, up_down, err_pulse, err_cnt, ab_state
  );
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder - quadrature encoder front end for a MOD-N up/down counter.
//
// Synchronises the asynchronous A/B channels, decodes Gray-code transitions
// and emits a registered one-cycle step pulse with a held direction level.
// Double-bit transitions raise err_pulse and bump a saturating err_cnt.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : quad_step_if.slave
//              enc_a/enc_b (async pins), enable, clr_err  -> in
//              step, up_down, err_pulse, err_cnt, ab_state -> out
//
// Parameters: SYNC_STAGES (>=2), MODE (1/2/4 steps per cycle),
//             FILT_LEN (>=1, glitch filter length), ERR_CNT_W.
// Optional feature macro: QUAD_FILTER_EN adds a per-channel glitch filter
// between the synchroniser and the decoder (latency grows by FILT_LEN).
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 4,
  parameter int FILT_LEN    = 4,
  parameter int ERR_CNT_W   = 8
) (
  input logic        clk,
  input logic        reset,
  quad_step_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("quad_step_decoder: SYNC_STAGES must be >= 2");
  end
  if (MODE != 1 && MODE != 2 && MODE != 4) begin : g_bad_mode
    $error("quad_step_decoder: MODE must be 1, 2 or 4");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("quad_step_decoder: FILT_LEN must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             w_sync_ab;
  logic [1:0]             w_cur_ab;

  // Stage: synchroniser chains
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], bus.enc_a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.enc_b};
    end
  end

  assign w_sync_ab = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QUAD_FILTER_EN
  localparam int FCNT_W       = $clog2(FILT_LEN + 1);
  localparam int PRIME_CYCLES = SYNC_STAGES + FILT_LEN + 1;

  logic [1:0]        r_filt;
  logic [FCNT_W-1:0] r_fcnt [2];

  // Stage: glitch filter. The filtered bit follows the synchronised bit only
  // on the FILT_LEN-th consecutive cycle of disagreement; any agreement
  // restarts that channel's count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt    <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync_ab[i] != r_filt[i]) begin
          if (r_fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
            r_filt[i] <= w_sync_ab[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  assign w_cur_ab = r_filt;
`else
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;

  assign w_cur_ab = w_sync_ab;
`endif

  // Priming: after reset, wait until the pipeline holds real pin values and
  // prev_ab has copied them, so a resting encoder never looks like an edge.
  localparam int PCNT_W = $clog2(PRIME_CYCLES + 1);

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PCNT_W-1:0] r_prime_cnt;
  logic              w_primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_PRIME;
      r_prime_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_PRIME) r_prime_cnt <= r_prime_cnt + PCNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_primed    = 1'b0;
    case (r_state)
      ST_PRIME: if (r_prime_cnt == PCNT_W'(PRIME_CYCLES - 1)) w_state_nxt = ST_RUN;
      ST_RUN:   w_primed = 1'b1;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  logic [1:0]           r_prev_ab;
  logic                 w_fwd;
  logic                 w_rev;
  logic                 w_err;
  logic                 w_qual;
  logic                 w_step;
  logic                 r_step;
  logic                 r_up_down;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Transition classifier. Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    w_fwd = (r_prev_ab == 2'b00 && w_cur_ab == 2'b10) ||
            (r_prev_ab == 2'b10 && w_cur_ab == 2'b11) ||
            (r_prev_ab == 2'b11 && w_cur_ab == 2'b01) ||
            (r_prev_ab == 2'b01 && w_cur_ab == 2'b00);
    w_rev = (r_prev_ab == 2'b10 && w_cur_ab == 2'b00) ||
            (r_prev_ab == 2'b11 && w_cur_ab == 2'b10) ||
            (r_prev_ab == 2'b01 && w_cur_ab == 2'b11) ||
            (r_prev_ab == 2'b00 && w_cur_ab == 2'b01);
    w_err = w_primed && ((r_prev_ab ^ w_cur_ab) == 2'b11);
    case (MODE)
      // Only the 00<->10 edge counts: fwd from 00 or rev from 10.
      1:       w_qual = (w_fwd && r_prev_ab == 2'b00) || (w_rev && r_prev_ab == 2'b10);
      2:       w_qual = (w_fwd || w_rev) && (r_prev_ab[1] ^ w_cur_ab[1]);
      default: w_qual = w_fwd || w_rev;
    endcase
    w_step = w_primed && w_qual && bus.enable;
  end

  // Stage: registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_ab   <= '0;
      r_step      <= 1'b0;
      r_up_down   <= 1'b1;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_prev_ab   <= w_cur_ab;
      r_step      <= w_step;
      r_err_pulse <= w_err;
      if (w_step) r_up_down <= w_fwd;
      if (bus.clr_err) begin
        r_err_cnt <= '0;
      end else if (w_err && r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.step      = r_step;
  assign bus.up_down   = r_up_down;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.ab_state  = w_cur_ab;

endmodule
